// File: rtl/pipe_load_rd.sv
// Load pipeline over a 256x16 data memory with register-bank write-back.
// Latency: 2 cycles from request accept to rsp_valid; 1 load/cycle sustained.
// Backpressure: rsp_ready low stalls S2 then S1; req_ready drops only when both are full.
module pipe_load_rd #(
    parameter int DW   = 16,
    parameter int AW   = 8,
    parameter int RW   = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [RW-1:0]   req_rd,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_waddr,
    input  logic [DW-1:0]   mem_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic [RW-1:0]   rsp_rd,
    output logic            rf_we,
    output logic [RW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata,
    output logic [CNTW-1:0] done_cnt
);

    logic [DW-1:0]   r_mem [0:(1<<AW)-1];

    logic            r_s1_v;
    logic [AW-1:0]   r_s1_addr;
    logic [RW-1:0]   r_s1_rd;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic [RW-1:0]   r_rsp_rd;
    logic [CNTW-1:0] r_done_cnt;

    logic            w_s2_acc;
    logic            w_s1_move;
    logic            w_req_acc;
    logic            w_rsp_hs;
    logic [DW-1:0]   w_rd_data;

    assign w_s2_acc  = !r_rsp_valid || rsp_ready;
    assign w_s1_move = r_s1_v && w_s2_acc;
    assign req_ready = !r_s1_v || w_s2_acc;
    assign w_req_acc = req_valid && req_ready;
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;

    // Write-first: a store landing on the address being read this cycle wins.
    assign w_rd_data = (mem_we && (mem_waddr == r_s1_addr)) ? mem_wdata : r_mem[r_s1_addr];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            r_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_addr <= '0;
            r_s1_rd   <= '0;
        end else if (w_req_acc) begin
            r_s1_v    <= 1'b1;
            r_s1_addr <= req_addr;
            r_s1_rd   <= req_rd;
        end else if (w_s1_move) begin
            r_s1_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_rd    <= '0;
        end else if (w_s1_move) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_data;
            r_rsp_rd    <= r_s1_rd;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (w_rsp_hs) begin
            r_done_cnt <= r_done_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;
    assign rf_we     = w_rsp_hs;
    assign rf_waddr  = r_rsp_rd;
    assign rf_wdata  = r_rsp_data;
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_pipe_load_rd.sv
// Bench for pipe_load_rd: directed scenarios plus random load traffic scored
// against a memory array and an in-order queue of outstanding loads.
module tb_pipe_load_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [3:0]  req_rd;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_rd;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] done_cnt;

    logic        s_req_ready;
    logic        s_rsp_valid;
    logic [15:0] s_rsp_data;
    logic [3:0]  s_rsp_rd;
    logic        s_rf_we;
    logic [3:0]  s_rf_waddr;
    logic [15:0] s_rf_wdata;
    logic [3:0]  s_done_cnt;

    pipe_load_rd dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_rd(req_rd),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .done_cnt(done_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used to observe wrap.
    pipe_load_rd #(.CNTW(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_addr(req_addr), .req_rd(req_rd),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data), .rsp_rd(s_rsp_rd),
        .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata), .done_cnt(s_done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  rd;
    } ld_t;

    logic [15:0] mmem [0:255];
    ld_t         q[$];
    int          n_done;
    int          n_pass;
    int          n_total;
    logic        hs_seen;
    logic        acc_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive, check against the model, update the model, advance.
    task automatic tick(input logic rv, input logic [7:0] a, input logic [3:0] rd,
                        input logic rr, input logic we, input logic [7:0] wa,
                        input logic [15:0] wd);
        ld_t e;
        req_valid = rv; req_addr = a; req_rd = rd; rsp_ready = rr;
        mem_we = we; mem_waddr = wa; mem_wdata = wd;
        #1;
        acc_seen = req_valid && req_ready;
        hs_seen  = rsp_valid && rsp_ready;
        chk("req_ready", {31'd0, req_ready}, {31'd0, (q.size() < 2) || rr});
        chk("rf_we", {31'd0, rf_we}, {31'd0, hs_seen});
        chk("done_cnt", {16'd0, done_cnt}, n_done);
        chk("done_cnt_small", {28'd0, s_done_cnt}, n_done % 16);
        if (q.size() == 0) chk("idle_rsp_valid", {31'd0, rsp_valid}, 0);
        if (hs_seen) begin
            if (q.size() == 0) begin
                chk("spurious_rsp", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
                chk("rsp_rd", {28'd0, rsp_rd}, {28'd0, e.rd});
                chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, e.data});
                chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, e.rd});
                n_done++;
            end
        end
        if (acc_seen) begin
            e.data = mmem[a];
            e.rd   = rd;
            q.push_back(e);
        end
        if (we) mmem[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() > 0; k++) tick(0, 0, 0, 1, 0, 0, 0);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          pending;
        int          base;
        logic [15:0] held;
        logic [15:0] v;
        n_done = 0; n_pass = 0; n_total = 0;
        rst_n = 1'b0; req_valid = 0; req_addr = 0; req_rd = 0;
        rsp_ready = 1; mem_we = 0; mem_waddr = 0; mem_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_done_cnt", {16'd0, done_cnt}, 0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 1);

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            if (i < 8) v = 16'(i * 3);
            if (i == 'h10) v = 16'hA5A5;
            if (i == 'h20) v = 16'h1111;
            tick(0, 0, 0, 1, 1, 8'(i), v);
        end

        // Single load: response appears two cycles after acceptance.
        tick(1, 8'h10, 4'd3, 1, 0, 0, 0);
        chk("single_acc", {31'd0, acc_seen}, 1);
        tick(0, 0, 0, 1, 0, 0, 0);
        chk("single_early", {31'd0, hs_seen}, 0);
        tick(0, 0, 0, 1, 0, 0, 0);
        chk("single_hs", {31'd0, hs_seen}, 1);
        chk("single_cnt", {16'd0, done_cnt}, 1);

        // Back-to-back streaming, one beat per cycle.
        base = n_done;
        for (int i = 0; i < 10; i++) begin
            tick(i < 8, 8'(i), 4'(i), 1, 0, 0, 0);
            if (i >= 2) chk("stream_beat", {31'd0, hs_seen}, 1);
        end
        chk("stream_cnt", {16'd0, done_cnt}, base + 8);

        // Backpressure: 5 stalled cycles during a 4-request burst.
        pending = 4;
        held = 0;
        for (int k = 0; k < 5; k++) begin
            tick(pending > 0, 8'(8'h40 + 4 - pending), 4'(pending), 0, 0, 0, 0);
            if (acc_seen) pending--;
            if (k == 1) held = rsp_data;
        end
        chk("bp_accepts", 4 - pending, 2);
        chk("bp_stable", {16'd0, rsp_data}, {16'd0, held});
        chk("bp_stalled_ready", {31'd0, req_ready}, 0);
        for (int k = 0; k < 30 && (pending > 0 || q.size() > 0); k++) begin
            tick(pending > 0, 8'(8'h40 + 4 - pending), 4'(pending), 1, 0, 0, 0);
            if (acc_seen) pending--;
        end
        chk("bp_complete", pending + q.size(), 0);

        // Store hits the address as S1 moves into S2: bypassed data returned.
        tick(1, 8'h20, 4'd5, 1, 0, 0, 0);
        q[q.size() - 1].data = 16'h2222;
        tick(0, 0, 0, 1, 1, 8'h20, 16'h2222);
        chk("coll_rsp", {16'd0, rsp_data}, 32'h2222);
        tick(0, 0, 0, 1, 0, 0, 0);
        tick(1, 8'h20, 4'd6, 1, 0, 0, 0);
        drain();
        chk("coll_reread", {16'd0, rsp_data}, 32'h2222);

        // Store to an address already held in a stalled S2 leaves it alone.
        held = mmem[8'h30];
        tick(1, 8'h30, 4'd7, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 8'h30, ~held);
        chk("s2_write_hold", {16'd0, rsp_data}, {16'd0, held});
        drain();

        for (int k = 0; k < 300; k++)
            tick($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), 4'($urandom),
                 $urandom_range(0, 3) != 0, 0, 0, 0);
        drain();

        // Reset mid-stream drops everything in flight.
        tick(1, 8'h01, 4'd1, 0, 0, 0, 0);
        tick(1, 8'h02, 4'd2, 0, 0, 0, 0);
        rsp_ready = 1; req_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("mid_rst_done_cnt", {16'd0, done_cnt}, 0);
        chk("mid_rst_rf_we", {31'd0, rf_we}, 0);
        chk("mid_rst_small_cnt", {28'd0, s_done_cnt}, 0);
        q.delete();
        n_done = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 1);
        @(posedge clk);
        #1;

        // 17 completions wrap a 4-bit counter to 1.
        for (int k = 0; k < 17; k++) tick(1, 8'(k), 4'(k), 1, 0, 0, 0);
        drain();
        chk("wrap_small", {28'd0, s_done_cnt}, 1);
        chk("wrap_big", {16'd0, done_cnt}, 17);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
